// File: rtl/psr_pkg.sv
// psr_pkg: shared state encoding, counter sizing and per-state output vectors for the reset sequencer
package psr_pkg;
  typedef enum logic [2:0] {ASSERT, HOLD, REL_BUS, REL_IC, REL_PER, RUN} psr_state_t;
  // Output vector layout: {bus_struct_reset, interconnect_aresetn, peripheral_aresetn, mb_reset}
  localparam logic [3:0] OUT_RESET = 4'b1001;
  localparam logic [3:0] OUT_BUS   = 4'b0001;
  localparam logic [3:0] OUT_IC    = 4'b0101;
  localparam logic [3:0] OUT_PER   = 4'b0111;
  localparam logic [3:0] OUT_RUN   = 4'b0110;
  function automatic int cnt_w(int hold_cycles, int stage_gap);
    return $clog2(hold_cycles > stage_gap ? hold_cycles : stage_gap) + 1;
  endfunction
  function automatic logic [3:0] out_vec(psr_state_t s);
    return s == RUN ? OUT_RUN : s == REL_PER ? OUT_PER : s == REL_IC ? OUT_IC :
           s == REL_BUS ? OUT_BUS : OUT_RESET;
  endfunction
endpackage

// File: rtl/psr_input_filter.sv
// psr_input_filter: synchronizes one async reset source, normalizes it to active-high and glitch-filters it
module psr_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER = 4,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic req
);
  logic [SYNC_STAGES-1:0] sync;
  logic s;
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], pin};
  end
  assign s = (ACTIVE_HIGH != 0) ? sync[SYNC_STAGES-1] : ~sync[SYNC_STAGES-1];
  generate
    if (FILTER <= 1) begin : g_pass
      // A one-cycle filter qualifies every sample, so the synchronized level is used directly.
      assign req = s;
    end else begin : g_filt
      localparam int CW = $clog2(FILTER);
      logic [CW-1:0] cnt;
      logic q;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
          q <= 1'b0;
        end else begin
          cnt <= !s ? '0 : cnt == CW'(FILTER - 1) ? cnt : cnt + 1'b1;
          q <= s && cnt == CW'(FILTER - 1);
        end
      end
      assign req = q;
    end
  endgenerate
endmodule

// File: rtl/psr_reset_seq.sv
// psr_reset_seq: holds all domain resets while any request is present, then releases bus, interconnect, peripheral, processor in order
module psr_reset_seq
  import psr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EXT_FILTER = 4,
  parameter int AUX_FILTER = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP = 16,
  parameter int EXT_RESET_ACTIVE_HIGH = 1,
  parameter int AUX_RESET_ACTIVE_HIGH = 0
) (
  input  logic aclk,
  input  logic rst,
  input  logic ext_reset_in,
  input  logic aux_reset_in,
  input  logic mb_debug_sys_rst,
  input  logic dcm_locked,
  output logic bus_struct_reset,
  output logic interconnect_aresetn,
  output logic peripheral_aresetn,
  output logic peripheral_reset,
  output logic mb_reset,
  output logic rst_busy
);
  localparam int CW = cnt_w(HOLD_CYCLES, STAGE_GAP);
  logic ext_q, aux_q, dbg_s, lock_req, any_req, done;
  logic [CW-1:0] cnt;
  logic [3:0] ov;
  psr_state_t state, nxt;
  psr_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(EXT_FILTER), .ACTIVE_HIGH(EXT_RESET_ACTIVE_HIGH))
    u_ext (.clk(aclk), .rst(rst), .pin(ext_reset_in), .req(ext_q));
  psr_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(AUX_FILTER), .ACTIVE_HIGH(AUX_RESET_ACTIVE_HIGH))
    u_aux (.clk(aclk), .rst(rst), .pin(aux_reset_in), .req(aux_q));
  psr_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(1), .ACTIVE_HIGH(1))
    u_dbg (.clk(aclk), .rst(rst), .pin(mb_debug_sys_rst), .req(dbg_s));
  psr_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(1), .ACTIVE_HIGH(0))
    u_lock (.clk(aclk), .rst(rst), .pin(dcm_locked), .req(lock_req));
  assign any_req = ext_q | aux_q | dbg_s | lock_req;
  // HOLD ends one count later than a gap: the edge leaving ASSERT is itself the first hold cycle.
  always_comb begin
    done = state == HOLD ? cnt == CW'(HOLD_CYCLES) : cnt == CW'(STAGE_GAP - 1);
    nxt = any_req ? ASSERT : state == ASSERT ? HOLD : state == RUN ? RUN :
          done ? psr_state_t'(state + 3'd1) : state;
    ov = out_vec(nxt);
  end
  always_ff @(posedge aclk) begin
    if (rst) begin
      state <= ASSERT;
      cnt <= '0;
      {bus_struct_reset, interconnect_aresetn, peripheral_aresetn, mb_reset} <= OUT_RESET;
      peripheral_reset <= 1'b1;
      rst_busy <= 1'b1;
    end else begin
      state <= nxt;
      cnt <= (nxt != state || state == ASSERT || state == RUN) ? '0 : cnt + 1'b1;
      {bus_struct_reset, interconnect_aresetn, peripheral_aresetn, mb_reset} <= ov;
      peripheral_reset <= ~ov[1];
      rst_busy <= nxt != RUN;
    end
  end
endmodule

// File: tb/tb_psr_reset_seq.sv
// tb_psr_reset_seq: randomized/directed stimulus, pin-history reference model and a queue-based output scoreboard
module tb_psr_reset_seq;
  localparam int SYNC = 2, EF = 4, AF = 4, H = 16, G = 16, NMAX = 20000;
  logic aclk = 0, rst = 1, ext_reset_in = 0, aux_reset_in = 1, mb_debug_sys_rst = 0, dcm_locked = 1;
  logic bus_struct_reset, interconnect_aresetn, peripheral_aresetn, peripheral_reset, mb_reset, rst_busy;
  always #5 aclk = ~aclk;
  psr_reset_seq dut (
    .aclk(aclk), .rst(rst), .ext_reset_in(ext_reset_in), .aux_reset_in(aux_reset_in),
    .mb_debug_sys_rst(mb_debug_sys_rst), .dcm_locked(dcm_locked),
    .bus_struct_reset(bus_struct_reset), .interconnect_aresetn(interconnect_aresetn),
    .peripheral_aresetn(peripheral_aresetn), .peripheral_reset(peripheral_reset),
    .mb_reset(mb_reset), .rst_busy(rst_busy)
  );
  bit pe[NMAX], pa[NMAX], pd[NMAX], pl[NMAX];
  bit ce = 0, ca = 1, cd = 0, cl = 1, req_prev = 1;
  int cyc = 0, lr = 0, run = 0, vectors = 0, miscompares = 0;
  logic [5:0] exp_q[$];
  // Raw pin value held by the synchronizer for the sample taken at edge j; a block reset wipes older samples.
  function automatic bit smp(int sel, int j);
    if (j < 1 || j <= lr) return 1'b0;
    return sel == 0 ? pe[j] : sel == 1 ? pa[j] : sel == 2 ? pd[j] : pl[j];
  endfunction
  function automatic bit nreq(int sel, int j);
    bit b = smp(sel, j);
    return (sel == 1 || sel == 3) ? ~b : b;
  endfunction
  function automatic bit qual(int sel, int f, int m);
    for (int j = m - f + 1; j <= m; j++)
      if (j <= lr || !nreq(sel, j - SYNC)) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic [5:0] expv(int r);
    bit b = r >= H + 2, i = r >= H + 2 + G, p = r >= H + 2 + 2 * G, u = r >= H + 2 + 3 * G;
    return {~b, i, p, ~p, ~u, ~u};
  endfunction
  task automatic tick(bit r = 0);
    int m;
    @(negedge aclk);
    m = cyc + 1;
    if (m >= NMAX) begin
      $display("FAIL model history: cycle %0d required below %0d", m, NMAX);
      $fatal(1);
    end
    rst = r; ext_reset_in = ce; aux_reset_in = ca; mb_debug_sys_rst = cd; dcm_locked = cl;
    pe[m] = ce; pa[m] = ca; pd[m] = cd; pl[m] = cl;
    @(posedge aclk);
    #1;
    cyc = m;
    if (r) lr = m;
    run = (r || req_prev) ? 0 : (run < 1000 ? run + 1 : run);
    req_prev = qual(0, EF, m) | qual(1, AF, m) | nreq(2, m - SYNC + 1) | nreq(3, m - SYNC + 1);
    exp_q.push_back(expv(run));
  endtask
  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic idle(int n);
    ce = 0; ca = 1; cd = 0; cl = 1;
    ticks(n);
  endtask
  task automatic wait_run(int lo, int hi, int budget);
    int k = 0;
    while ((run < lo || run > hi) && k < budget) begin
      tick();
      k++;
    end
    vectors++;
    if (run < lo || run > hi) begin
      miscompares++;
      $display("FAIL wait_run: release count %0d after %0d cycles, required %0d..%0d", run, k, lo, hi);
    end
  endtask
  always @(negedge aclk) begin
    if (exp_q.size() > 0) begin
      logic [5:0] e, got;
      e = exp_q.pop_front();
      got = {bus_struct_reset, interconnect_aresetn, peripheral_aresetn, peripheral_reset, mb_reset, rst_busy};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL outputs @cycle %0d: got %b required %b", cyc, got, e);
      end
    end
  end
  initial begin
    repeat (3) tick(1);
    idle(90);
    ce = 1; ticks(3); idle(20);
    ce = 1; ticks(4); idle(90);
    cd = 1; ticks(2); idle(0);
    wait_run(H + 2 + G, H + 1 + 2 * G, 200);
    cl = 0; ticks(1); idle(90);
    ca = 0; ticks(5); ce = 1; ticks(10); ca = 1; ticks(10); idle(90);
    cd = 1; ticks(2); idle(0);
    wait_run(H - 1, H - 1, 60);
    cd = 1; ticks(1); idle(90);
    cd = 1; ticks(2); idle(0);
    wait_run(H + 2 + 2 * G, H + 1 + 3 * G, 200);
    tick(1);
    idle(90);
    for (int s = 0; s < 150; s++) begin
      int kind = $urandom_range(0, 9), len = $urandom_range(1, 6);
      idle(0);
      if (kind <= 3) begin ce = 1; ticks(len); end
      else if (kind <= 5) begin ca = 0; ticks(len); end
      else if (kind == 6) begin cd = 1; ticks(len); end
      else if (kind == 7) begin cl = 0; ticks(len); end
      else if (kind == 8) ticks($urandom_range(20, 80));
      else repeat ($urandom_range(1, 2)) tick(1);
      idle($urandom_range(0, 30));
    end
    idle(80);
    repeat (2) @(negedge aclk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
